// File: rtl/register_file.sv
// register_file: 8 x 16-bit general-purpose registers for the CPU datapath.
// One synchronous write port (W) and three combinational read ports (A, B, D),
// each driving a shared datapath bus and releasing it to high impedance when idle.
module register_file #(
    localparam int unsigned DATA_W = 16,
    localparam int unsigned DEPTH  = 8,
    localparam int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_w,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic              en_w,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              en_a,
    output logic [DATA_W-1:0] bus_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              en_b,
    output logic [DATA_W-1:0] bus_b,
    input  logic [ADDR_W-1:0] addr_d,
    input  logic              en_d,
    output logic [DATA_W-1:0] bus_d
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_rd_d;

    // Storage: async clear on reset low, otherwise write on enabled rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (en_w) begin
            r_mem[addr_w] <= bus_w;
        end
    end

    // Read ports see stored contents only; no write-through bypass
    assign w_rd_a = r_mem[addr_a];
    assign w_rd_b = r_mem[addr_b];
    assign w_rd_d = r_mem[addr_d];

    // Bus drivers release to high impedance when the port is not enabled
    assign bus_a = en_a ? w_rd_a : {DATA_W{1'bz}};
    assign bus_b = en_b ? w_rd_b : {DATA_W{1'bz}};
    assign bus_d = en_d ? w_rd_d : {DATA_W{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file. Buses are pulled high so a released (Z) bus reads 16'hFFFF.
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [15:0] bus_w;
    logic [2:0]  addr_w;
    logic        en_w;
    logic [2:0]  addr_a;
    logic        en_a;
    logic [2:0]  addr_b;
    logic        en_b;
    logic [2:0]  addr_d;
    logic        en_d;
    tri1  [15:0] bus_a;
    tri1  [15:0] bus_b;
    tri1  [15:0] bus_d;

    int checks;
    int errors;

    localparam logic [15:0] ZPULL = 16'hFFFF;

    typedef struct {
        logic        we;
        logic [2:0]  aw;
        logic [15:0] dw;
        logic [2:0]  aa;
        logic        ea;
        logic [2:0]  ab;
        logic        eb;
        logic [2:0]  ad;
        logic        ed;
        logic [15:0] xa;
        logic [15:0] xb;
        logic [15:0] xd;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
    } exp_t;

    vec_t vecs[10];
    exp_t exp_q[$];

    register_file dut (
        .clk    (clk),
        .reset  (reset),
        .bus_w  (bus_w),
        .addr_w (addr_w),
        .en_w   (en_w),
        .addr_a (addr_a),
        .en_a   (en_a),
        .bus_a  (bus_a),
        .addr_b (addr_b),
        .en_b   (en_b),
        .bus_b  (bus_b),
        .addr_d (addr_d),
        .en_d   (en_d),
        .bus_d  (bus_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string name, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] d);
        exp_t e;
        e.name = name;
        e.a = a;
        e.b = b;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check_one(input string name, input string port,
                             input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", name, port, act, req);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, got nothing, expected an entry");
        end else begin
            e = exp_q.pop_front();
            check_one(e.name, "bus_a", bus_a, e.a);
            check_one(e.name, "bus_b", bus_b, e.b);
            check_one(e.name, "bus_d", bus_d, e.d);
        end
    endtask

    task automatic set_reads(input logic [2:0] aa, input logic ea, input logic [2:0] ab,
                             input logic eb, input logic [2:0] ad, input logic ed);
        addr_a = aa; en_a = ea;
        addr_b = ab; en_b = eb;
        addr_d = ad; en_d = ed;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //             we   aw    dw        aa   ea   ab   eb   ad   ed   xa        xb        xd
        vecs[0] = '{1'b1, 3'd1, 16'h0271, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 16'h0271, ZPULL,    16'h0000};
        vecs[1] = '{1'b1, 3'd2, 16'h000C, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 16'h0271, ZPULL,    16'h000C};
        vecs[2] = '{1'b0, 3'd1, 16'hFFFF, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 16'h0271, 16'h0271, 16'h000C};
        vecs[3] = '{1'b1, 3'd0, 16'h0272, 3'd1, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1, 16'h0271, 16'h0272, 16'h000C};
        vecs[4] = '{1'b1, 3'd3, 16'h1111, 3'd3, 1'b1, 3'd3, 1'b1, 3'd0, 1'b1, 16'h1111, 16'h1111, 16'h0272};
        vecs[5] = '{1'b1, 3'd7, 16'h8001, 3'd7, 1'b1, 3'd7, 1'b0, 3'd0, 1'b1, 16'h8001, ZPULL,    16'h0272};
        vecs[6] = '{1'b1, 3'd4, 16'hFFFF, 3'd4, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 3'd5, 16'h00A5, 3'd5, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 16'h00A5, 16'h00A5, 16'h00A5};
        vecs[8] = '{1'b1, 3'd6, 16'h5A5A, 3'd6, 1'b1, 3'd6, 1'b0, 3'd6, 1'b0, 16'h5A5A, ZPULL,    ZPULL};
        vecs[9] = '{1'b1, 3'd1, 16'h4321, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 16'h4321, 16'h000C, 16'h1111};

        // Reset held: writes attempted on edges must not land
        reset  = 1'b0;
        en_w   = 1'b1;
        addr_w = 3'd0;
        bus_w  = 16'hABCD;
        set_reads(3'd0, 1'b1, 3'd5, 1'b1, 3'd7, 1'b1);
        #1;
        push_exp("reset_initial", 16'h0000, 16'h0000, 16'h0000);
        pop_check();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr_w = 3'(i);
            bus_w  = 16'hA000 | 16'(i);
            set_reads(3'(i), 1'b1, 3'(7 - i), 1'b1, 3'(i), 1'b0);
            @(posedge clk);
            #1;
            push_exp($sformatf("reset_write_blocked_%0d", i), 16'h0000, 16'h0000, ZPULL);
            pop_check();
        end

        // Release reset between edges; table vectors follow
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en_w   = vecs[i].we;
            addr_w = vecs[i].aw;
            bus_w  = vecs[i].dw;
            set_reads(vecs[i].aa, vecs[i].ea, vecs[i].ab, vecs[i].eb, vecs[i].ad, vecs[i].ed);
            push_exp($sformatf("vec%0d", i), vecs[i].xa, vecs[i].xb, vecs[i].xd);
            @(posedge clk);
            #1;
            pop_check();
        end

        // Read-during-write: old value before the edge, new value after it
        @(negedge clk);
        en_w   = 1'b1;
        addr_w = 3'd3;
        bus_w  = 16'h2222;
        set_reads(3'd3, 1'b1, 3'd3, 1'b0, 3'd1, 1'b1);
        #1;
        push_exp("rdw_before_edge", 16'h1111, ZPULL, 16'h4321);
        pop_check();
        @(posedge clk);
        #1;
        push_exp("rdw_after_edge", 16'h2222, ZPULL, 16'h4321);
        pop_check();

        // Address/data wiggle between edges with write disabled leaves storage alone
        @(negedge clk);
        en_w   = 1'b0;
        addr_w = 3'd3;
        bus_w  = 16'hDEAD;
        #2;
        addr_w = 3'd1;
        bus_w  = 16'hBEEF;
        @(posedge clk);
        #1;
        push_exp("no_write_when_disabled", 16'h2222, ZPULL, 16'h4321);
        pop_check();

        // Async reset mid-cycle: buses clear with no clock edge
        @(negedge clk);
        set_reads(3'd1, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        push_exp("async_reset_immediate", 16'h0000, 16'h0000, 16'h0000);
        pop_check();
        set_reads(3'd4, 1'b1, 3'd5, 1'b0, 3'd6, 1'b1);
        #1;
        push_exp("async_reset_other_regs", 16'h0000, ZPULL, 16'h0000);
        pop_check();

        // Reset asserted across a write edge: reset wins
        en_w   = 1'b1;
        addr_w = 3'd3;
        bus_w  = 16'hBEEF;
        set_reads(3'd3, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0);
        @(posedge clk);
        #1;
        push_exp("reset_wins_on_edge", 16'h0000, 16'h0000, ZPULL);
        pop_check();

        // First write lands on the first rising edge after release
        @(negedge clk);
        reset  = 1'b1;
        addr_w = 3'd2;
        bus_w  = 16'h0099;
        set_reads(3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1);
        @(posedge clk);
        #1;
        push_exp("first_write_after_release", 16'h0099, 16'h0000, 16'h0000);
        pop_check();

        @(negedge clk);
        en_w = 1'b0;

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
